// File: rtl/vga_draw_arbiter_pkg.sv
//==== vga_draw_arbiter_pkg : shared FSM encoding, VGA widths, watchdog default ====
//==== rev 1.0                                                                 ====
`default_nettype none

package vga_draw_arbiter_pkg;

  localparam int X_W            = 8;
  localparam int Y_W            = 7;
  localparam int COL_W          = 9;
  localparam int CNT_W          = 14;
  localparam int MAX_CYCLES_DEF = 16383;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DRAW    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vga_draw_arbiter_rr_pick.sv
//==== vga_draw_arbiter_rr_pick : first set request at or after rr_ptr, wrapping ====
//==== rev 1.0                                                                   ====
`default_nettype none

module vga_draw_arbiter_rr_pick
  import vga_draw_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand     = (int'(rr_ptr_i) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
//==== vga_draw_arbiter : sequences ROM drawers one at a time onto the VGA write port ====
//==== rev 1.0                                                                        ====
`default_nettype none

module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IDX_W      = 2,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [X_W*N_REQ-1:0]   draw_x_i,
  input  logic [Y_W*N_REQ-1:0]   draw_y_i,
  input  logic [COL_W*N_REQ-1:0] draw_colour_i,
  input  logic [N_REQ-1:0]       draw_done_i,
  output logic [N_REQ-1:0]       draw_resetn_o,
  output logic [N_REQ-1:0]       served_o,
  output logic [X_W-1:0]         vga_x_o,
  output logic [Y_W-1:0]         vga_y_o,
  output logic [COL_W-1:0]       vga_colour_o,
  output logic                   vga_plot_o,
  output logic                   busy_o,
  output logic                   timeout_err_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             to_exit_q, to_exit_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] grant_oh;

  vga_draw_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      to_exit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      to_exit_q <= to_exit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    to_exit_d = to_exit_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          gidx_d    = pick_idx;
          to_exit_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_DRAW;
      ST_DRAW: begin
        if (cnt_q != CNT_W'(MAX_CYCLES)) cnt_d = cnt_q + 1'b1;
        // A done on the watchdog's last cycle still counts as a normal finish.
        if (draw_done_i[gidx_q]) begin
          state_d = ST_FLUSH;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          timeout_d = 1'b1;
          to_exit_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_FLUSH: state_d = ST_RELEASE;
      ST_RELEASE: begin
        cnt_d    = '0;
        rr_ptr_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_oh         = '0;
    grant_oh[gidx_q] = 1'b1;
  end

  // Parking is gated by resetn directly so drawers stop in the same cycle.
  assign draw_resetn_o = (resetn && (state_q == ST_START || state_q == ST_DRAW)) ? grant_oh : '0;
  assign served_o      = (state_q == ST_RELEASE && !to_exit_q) ? grant_oh : '0;
  assign vga_plot_o    = (state_q == ST_DRAW) || (state_q == ST_FLUSH);
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_err_o = timeout_q;

  assign vga_x_o      = vga_plot_o ? draw_x_i[int'(gidx_q)*X_W +: X_W] : '0;
  assign vga_y_o      = vga_plot_o ? draw_y_i[int'(gidx_q)*Y_W +: Y_W] : '0;
  assign vga_colour_o = vga_plot_o ? draw_colour_i[int'(gidx_q)*COL_W +: COL_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter : directed scenarios with behavioural drawers and a grant scoreboard.
`default_nettype none

module tb_vga_draw_arbiter;

  localparam int N      = 4;
  localparam int IW     = 2;
  localparam int TB_MAX = 4000;
  localparam int BUDGET = 20000;

  typedef struct {
    int g;
    int plots;
    bit served;
    bit tmo;
  } exp_t;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req;
  logic [8*N-1:0] draw_x;
  logic [7*N-1:0] draw_y;
  logic [9*N-1:0] draw_col;
  logic [N-1:0]   draw_done;
  logic [N-1:0]   draw_resetn;
  logic [N-1:0]   served;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [8:0]     vga_col;
  logic           vga_plot;
  logic           busy;
  logic           terr;

  int             p    [N];
  int             dlen [N];
  logic [N-1:0]   spur;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             starts = 0;
  int             dones  = 0;
  int             plots  = 0;
  logic [N-1:0]   served_acc = '0;
  logic           prev_busy  = 1'b0;
  logic           tmo_sticky = 1'b0;

  vga_draw_arbiter #(
    .N_REQ      (N),
    .IDX_W      (IW),
    .MAX_CYCLES (TB_MAX)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_i         (req),
    .draw_x_i      (draw_x),
    .draw_y_i      (draw_y),
    .draw_colour_i (draw_col),
    .draw_done_i   (draw_done),
    .draw_resetn_o (draw_resetn),
    .served_o      (served),
    .vga_x_o       (vga_x),
    .vga_y_o       (vga_y),
    .vga_colour_o  (vga_col),
    .vga_plot_o    (vga_plot),
    .busy_o        (busy),
    .timeout_err_o (terr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mx(input int i, input int pp);
    return 8'((pp + i * 11) % 80);
  endfunction

  function automatic logic [6:0] my(input int pp);
    return 7'((pp / 80) % 128);
  endfunction

  function automatic logic [8:0] mc(input int i, input int pp);
    return 9'((pp * 3 + i * 37) % 512);
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Drawer model: pixel counter runs while enabled, parks to 0 otherwise.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) p[i] <= draw_resetn[i] ? p[i] + 1 : 0;
  end

  always_comb begin
    draw_x    = '0;
    draw_y    = '0;
    draw_col  = '0;
    draw_done = '0;
    for (int i = 0; i < N; i++) begin
      draw_x[i*8 +: 8]   = mx(i, p[i]);
      draw_y[i*7 +: 7]   = my(p[i]);
      draw_col[i*9 +: 9] = mc(i, p[i]);
      draw_done[i]       = spur[i] | (dlen[i] != 0 && p[i] == dlen[i]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t         e;
    logic [N-1:0] oh;
    int           g;
    @(posedge clk);
    #1;
    oh = (sb.size() != 0) ? onehot(sb[0].g) : '0;
    chk("park", 32'(draw_resetn & ~oh), 32'(0));
    if (busy && !prev_busy) begin
      starts++;
      chk("start_resetn", 32'(draw_resetn), 32'(oh));
      chk("start_plot", 32'(vga_plot), 32'(0));
    end
    if (vga_plot && sb.size() != 0) begin
      plots++;
      g = sb[0].g;
      chk("mux_x", 32'(vga_x), 32'(mx(g, p[g])));
      chk("mux_y", 32'(vga_y), 32'(my(p[g])));
      chk("mux_col", 32'(vga_col), 32'(mc(g, p[g])));
    end
    served_acc |= served;
    if (!busy && prev_busy) begin
      dones++;
      if (sb.size() == 0) begin
        chk("unexpected_grant", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        if (resetn) begin
          chk("plots", plots, e.plots);
          chk("served", 32'(served_acc), 32'(e.served ? onehot(e.g) : '0));
          tmo_sticky |= e.tmo;
          chk("timeout_err", 32'(terr), 32'(tmo_sticky));
          chk("rr_ptr", 32'(dut.rr_ptr_q), (e.g + 1) % N);
        end
      end
      plots      = 0;
      served_acc = '0;
    end
    prev_busy = busy;
  endtask

  task automatic wait_starts(input int n);
    int b = 0;
    while (starts < n && b < BUDGET) begin
      tick();
      b++;
    end
    chk("wait_start", 32'(starts >= n), 32'(1));
  endtask

  task automatic wait_dones(input int n);
    int b = 0;
    while (dones < n && b < BUDGET) begin
      tick();
      b++;
    end
    chk("wait_done", 32'(dones >= n), 32'(1));
  endtask

  task automatic chk_reset_state();
    chk("rst_draw_resetn", 32'(draw_resetn), 32'(0));
    chk("rst_served", 32'(served), 32'(0));
    chk("rst_vga_x", 32'(vga_x), 32'(0));
    chk("rst_vga_y", 32'(vga_y), 32'(0));
    chk("rst_vga_col", 32'(vga_col), 32'(0));
    chk("rst_plot", 32'(vga_plot), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_timeout", 32'(terr), 32'(0));
    chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'(0));
  endtask

  initial begin
    int s0;
    int d0;
    resetn = 1'b0;
    req    = '0;
    spur   = '0;
    for (int i = 0; i < N; i++) dlen[i] = 0;
    repeat (3) tick();
    chk_reset_state();
    resetn = 1'b1;
    tick();

    // Single request on drawer 2 with cycle-exact latency.
    dlen[2] = 3200;
    d0 = dones;
    sb.push_back('{g: 2, plots: 3201, served: 1'b1, tmo: 1'b0});
    chk("lat_idle_busy", 32'(busy), 32'(0));
    req = 4'b0100;
    tick();
    chk("lat_busy", 32'(busy), 32'(1));
    chk("lat_resetn", 32'(draw_resetn), 32'(4'b0100));
    chk("lat_noplot", 32'(vga_plot), 32'(0));
    req = '0;
    tick();
    chk("lat_plot", 32'(vga_plot), 32'(1));
    wait_dones(d0 + 1);

    // Spurious done from drawer 1 while drawer 0 runs.
    spur[1] = 1'b1;
    dlen[0] = 20;
    d0 = dones;
    s0 = starts;
    sb.push_back('{g: 0, plots: 21, served: 1'b1, tmo: 1'b0});
    req = 4'b0001;
    wait_starts(s0 + 1);
    req = '0;
    wait_dones(d0 + 1);
    spur[1] = 1'b0;

    // Watchdog on drawer 3, then drawer 0 is served.
    dlen[3] = 0;
    dlen[0] = 10;
    d0 = dones;
    s0 = starts;
    sb.push_back('{g: 3, plots: TB_MAX, served: 1'b0, tmo: 1'b1});
    sb.push_back('{g: 0, plots: 11, served: 1'b1, tmo: 1'b0});
    req = 4'b1001;
    wait_starts(s0 + 1);
    req = 4'b0001;
    wait_starts(s0 + 2);
    req = '0;
    wait_dones(d0 + 2);

    // Reset during DRAW cycle 50 of drawer 2, req held on drawers 0 and 2.
    dlen[2] = 1000;
    dlen[0] = 10;
    s0 = starts;
    sb.push_back('{g: 2, plots: 0, served: 1'b0, tmo: 1'b0});
    req = 4'b0101;
    wait_starts(s0 + 1);
    repeat (50) tick();
    chk("mid_plot", 32'(vga_plot), 32'(1));
    resetn = 1'b0;
    #1;
    chk("park_same_cycle", 32'(draw_resetn), 32'(0));
    tick();
    tmo_sticky = 1'b0;
    chk_reset_state();
    d0 = dones;
    s0 = starts;
    sb.push_back('{g: 0, plots: 11, served: 1'b1, tmo: 1'b0});
    resetn = 1'b1;
    wait_starts(s0 + 1);
    req = '0;
    wait_dones(d0 + 1);

    // Round-robin order from rr_ptr=0 with req=1011 held.
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("rr_start_ptr", 32'(dut.rr_ptr_q), 32'(0));
    dlen[0] = 5;
    dlen[1] = 7;
    dlen[3] = 9;
    d0 = dones;
    s0 = starts;
    sb.push_back('{g: 0, plots: 6, served: 1'b1, tmo: 1'b0});
    sb.push_back('{g: 1, plots: 8, served: 1'b1, tmo: 1'b0});
    sb.push_back('{g: 3, plots: 10, served: 1'b1, tmo: 1'b0});
    sb.push_back('{g: 0, plots: 6, served: 1'b1, tmo: 1'b0});
    req = 4'b1011;
    wait_starts(s0 + 4);
    req = '0;
    wait_dones(d0 + 4);
    repeat (4) tick();

    chk("sb_drained", sb.size(), 0);
    chk("final_idle", 32'(busy), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
